// File: rtl/component_labeling_engine.sv
// Connected-component labeler: loads a 32x32 binary image from ROM, grows each
// 8-connected object from its raster-first seed, and writes labels to SRAM.
//
// state | meaning
// LOAD  | stream 128 ROM bytes into the image register
// SEED  | scan for the first unlabeled foreground pixel
// GROW  | dilate the object mask within the foreground until stable
// WOBJ  | write the new label for every mask pixel, mark them labeled
// WBG   | write 0 to every background pixel
// DONE  | finish held high until reset
module component_labeling_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_q,
  output logic [6:0] rom_a,
  input  logic [7:0] sram_q,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  output logic       finish
);

  typedef enum logic [2:0] {
    LOAD = 3'd0,
    SEED = 3'd1,
    GROW = 3'd2,
    WOBJ = 3'd3,
    WBG  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [1023:0]  img, lab, mask, mask_grow;
  logic [7:0]     ld_cnt;
  logic [9:0]     idx;
  logic [9:0]     ld_base;
  logic [7:0]     label;
  logic           idx_last, seed_hit, grow_stable;
  logic           unused_sram;

  assign unused_sram = ^sram_q;
  assign idx_last    = (idx == 10'd1023);
  assign seed_hit    = img[idx] & ~lab[idx];
  assign grow_stable = (mask_grow == mask);
  assign ld_base     = {ld_cnt[6:0] - 7'd1, 3'b000};

  // Mask padded by a zero border so edge pixels see no wrap-around neighbours.
  logic [33:0] pm [34];
  always_comb begin
    for (int r = 0; r < 34; r++) pm[r] = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        pm[r+1][c+1] = mask[r*32+c];
  end

  for (genvar r = 0; r < 32; r++) begin : g_row
    for (genvar c = 0; c < 32; c++) begin : g_col
      assign mask_grow[r*32+c] = mask[r*32+c] |
        (img[r*32+c] & ((|pm[r][c+2:c]) | (|pm[r+1][c+2:c]) | (|pm[r+2][c+2:c])));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (ld_cnt == 8'd128) state_nx = SEED;
      SEED: begin
        if (seed_hit)      state_nx = GROW;
        else if (idx_last) state_nx = WBG;
      end
      GROW: if (grow_stable) state_nx = WOBJ;
      WOBJ: if (idx_last) state_nx = SEED;
      WBG:  if (idx_last) state_nx = DONE;
      DONE: state_nx = DONE;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      rom_a    <= '0;
      ld_cnt   <= '0;
      sram_a   <= '0;
      sram_d   <= '0;
      sram_wen <= 1'b1;
      finish   <= 1'b0;
      label    <= '0;
      idx      <= '0;
      img      <= '0;
      lab      <= '0;
      mask     <= '0;
    end else begin
      state    <= state_nx;
      sram_wen <= 1'b1;
      case (state)
        LOAD: begin
          if (rom_a != 7'd127) rom_a <= rom_a + 7'd1;
          // rom_q now holds the byte addressed on the previous cycle
          if (ld_cnt != 8'd0)
            for (int j = 0; j < 8; j++) img[ld_base + 10'(j)] <= rom_q[7-j];
          ld_cnt <= ld_cnt + 8'd1;
        end
        SEED: begin
          if (seed_hit) begin
            mask <= 1024'd1 << idx;
            idx  <= '0;
          end else begin
            idx <= idx + 10'd1;
          end
        end
        GROW: begin
          mask <= mask_grow;
          if (grow_stable) label <= label + 8'd1;
        end
        WOBJ: begin
          sram_a   <= idx;
          sram_d   <= label;
          sram_wen <= ~mask[idx];
          if (mask[idx]) lab[idx] <= 1'b1;
          idx <= idx + 10'd1;
        end
        WBG: begin
          sram_a   <= idx;
          sram_d   <= 8'd0;
          sram_wen <= img[idx];
          idx      <= idx + 10'd1;
        end
        DONE: finish <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_component_labeling_engine.sv
// Directed bench for component_labeling_engine with behavioural ROM/SRAM models
// and hand-computed label maps.
module tb_component_labeling_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rom_q;
  logic [6:0] rom_a;
  logic [7:0] sram_q;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  logic [7:0] rom_mem  [128];
  logic [7:0] sram_mem [1024];
  logic       wr_seen  [1024];
  logic [7:0] exp_lbl  [1024];
  logic       sram_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  component_labeling_engine dut (
    .clk(clk), .reset(reset), .rom_q(rom_q), .rom_a(rom_a), .sram_q(sram_q),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wen(sram_wen), .finish(finish)
  );

  always @(posedge clk) rom_q <= rom_mem[rom_a];

  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < 1024; i++) begin
        sram_mem[i] <= 8'h00;
        wr_seen[i]  <= 1'b0;
      end
    end else if (!sram_wen) begin
      sram_mem[sram_a] <= sram_d;
      wr_seen[sram_a]  <= 1'b1;
    end
    sram_q <= sram_mem[sram_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic clear_image();
    for (int a = 0; a < 128; a++) rom_mem[a] = 8'h00;
    for (int p = 0; p < 1024; p++) exp_lbl[p] = 8'h00;
  endtask

  task automatic set_px(input int r, input int c, input logic [7:0] l);
    int p;
    p = r * 32 + c;
    rom_mem[p / 8][7 - (p % 8)] = 1'b1;
    exp_lbl[p] = l;
  endtask

  task automatic start_run(input string tag);
    @(negedge clk);
    reset    = 1'b1;
    sram_clr = 1'b1;
    @(negedge clk);
    sram_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, " rst finish"}, 32'(finish), 32'd0);
    chk({tag, " rst wen"}, 32'(sram_wen), 32'd1);
    chk({tag, " rst rom_a"}, 32'(rom_a), 32'd0);
    reset = 1'b0;
  endtask

  task automatic wait_and_check(input string tag);
    int cyc;
    int bad_px;
    cyc = 0;
    while (finish !== 1'b1 && cyc < 300000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " finish seen"}, 32'(finish), 32'd1);
    bad_px = 0;
    for (int i = 0; i < 1024; i++) begin
      n_cmp++;
      assert ({wr_seen[i], sram_mem[i]} === {1'b1, exp_lbl[i]}) else begin
        n_bad++;
        bad_px++;
        if (bad_px <= 8)
          $error("FAIL %s px%0d: observed written=%0b label=%0h expected label=%0h",
                 tag, i, wr_seen[i], sram_mem[i], exp_lbl[i]);
      end
    end
    repeat (4) @(negedge clk);
    chk({tag, " finish held"}, 32'(finish), 32'd1);
    chk({tag, " idle wen"}, 32'(sram_wen), 32'd1);
  endtask

  task automatic build_blobs();
    clear_image();
    set_px(2, 2, 8'd1); set_px(2, 3, 8'd1); set_px(3, 2, 8'd1); set_px(3, 3, 8'd1);
    for (int r = 2; r <= 6; r++) begin
      set_px(r, 10, 8'd2);
      set_px(r, 14, 8'd2);
    end
    for (int c = 11; c <= 13; c++) set_px(6, c, 8'd2);
    set_px(2, 20, 8'd3);
    for (int c = 0; c < 32; c++) set_px(10, c, 8'd4);
    set_px(20, 30, 8'd5); set_px(21, 31, 8'd5); set_px(22, 30, 8'd5);
  endtask

  initial begin
    int cyc;

    clear_image();
    start_run("zero");
    wait_and_check("zero");

    for (int a = 0; a < 128; a++) rom_mem[a] = 8'hFF;
    for (int p = 0; p < 1024; p++) exp_lbl[p] = 8'h01;
    start_run("ones");
    wait_and_check("ones");

    clear_image();
    set_px(0, 0, 8'd1);
    set_px(1, 1, 8'd1);
    start_run("diag");
    wait_and_check("diag");

    clear_image();
    set_px(0, 31, 8'd1);
    set_px(1, 0, 8'd2);
    start_run("nowrap");
    wait_and_check("nowrap");

    build_blobs();
    start_run("blobs");
    wait_and_check("blobs");

    build_blobs();
    start_run("midrst");
    cyc = 0;
    while (dut.state !== 3'd2 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst reached grow", 32'(dut.state), 32'd2);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst finish low", 32'(finish), 32'd0);
    end
    reset = 1'b0;
    wait_and_check("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/component_labeling_engine.md
Name: component_labeling_engine

Overview:
Connected-component labeling engine for a 32x32 binary image. It reads the image from an external 128x8 synchronous ROM and writes one 8-bit label per pixel into an external 1024x8 synchronous SRAM: 0 for background, and a unique non-zero label per object. It raises `finish` when the SRAM holds the complete result. The block sits between the ROM and SRAM macros, and the system bench inspects SRAM contents after `finish`.

Parameters:
- None. Image size (32x32), label width (8) and memory sizes are fixed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_q  input  8  ROM read data; valid one cycle after `rom_a` is sampled.
- rom_a  output  7  ROM byte address.
- sram_q  input  8  SRAM read data; valid one cycle after `sram_a` is sampled with `sram_wen`=1. Use is optional.
- sram_a  output  10  SRAM address = row*32 + col.
- sram_d  output  8  SRAM write data (pixel label).
- sram_wen  output  1  SRAM write enable, active-low; 0 writes `sram_d` to `sram_a` at the clock edge.
- finish  output  1  result complete; held high until reset.

Behaviour:
- Reset values (synchronous, `reset`=1 at the edge): `rom_a`=0, `sram_a`=0, `sram_d`=0, `sram_wen`=1, `finish`=0. Internal label counter=0 and all state returns to LOAD.
- Reset asserted mid-operation aborts the current run and restarts from LOAD after release. Partial SRAM contents may remain; they are overwritten by the new run.
- Image format:
  - ROM byte a (0..127) holds pixels p = 8a .. 8a+7.
  - bit7 = pixel 8a (leftmost), bit0 = pixel 8a+7.
  - Pixel p is at row p/32, column p%32.
  - Bit 1 = foreground, 0 = background.
- Connectivity: 8-connected. Horizontal, vertical and diagonal neighbours of foreground pixels belong to the same object.
- Labels:
  - Every pixel of one object gets the same label.
  - Distinct objects get distinct labels in 1..255.
  - Labels are assigned in ascending order (1, 2, 3, ...) in the raster order of each object's first pixel (top row first, then left column first).
  - Designed for at most 255 objects; behaviour beyond that is undefined.
- Background pixels are written as 0. All 1024 SRAM addresses must be written exactly once-or-more before `finish`; no address may be left unwritten.
- States:
  - LOAD: issue `rom_a` 0..127 on consecutive cycles. Capture `rom_q` one cycle later into a 1024-bit internal image register (pipelined, 129 cycles).
  - SEED: raster-scan for the first foreground pixel not yet labeled. None left -> WBG.
  - GROW: set the object mask = {seed}. Repeatedly sweep all pixels, adding any foreground pixel 8-adjacent to the mask, until a full sweep adds nothing.
  - WOBJ: increment the label counter. Write that label to SRAM for every mask pixel (one write per cycle, `sram_wen`=0). Mark those pixels labeled, then go to SEED.
  - WBG: write 0 to every background pixel, one per cycle.
  - DONE: `finish`=1 registered, `sram_wen`=1, hold until reset.
- `sram_wen`=1 whenever no write is intended. `sram_a` and `sram_d` are meaningful only when `sram_wen`=0.
- `finish` rises only after the final write edge has completed.
- Latency bound: `finish` within 300000 cycles of reset release for any image with at most 5 objects.
- Boundaries:
  - Pixels on rows 0/31 and columns 0/31 have no neighbours outside the image; there is no wrap-around across row or column edges.
  - An all-zero image gives all SRAM = 0 and `finish`.
  - An all-one image gives all SRAM = 1.
  - A single isolated pixel forms its own object.

Test Plan:
- All-zero ROM -> every SRAM byte = 0x00, `finish`=1, no X in memory.
- All-0xFF ROM -> every SRAM byte = 0x01, `finish`=1.
- Two diagonally touching pixels (0,0) and (1,1), rest 0 -> both = 0x01, all others 0 (checks 8-connectivity).
- Pixels at (0,31) and (1,0) only -> labels 0x01 and 0x02, distinct (no row wrap-around).
- Five separated blobs, including a U-shape whose arms meet only at the bottom -> each blob uniform, labels 1..5 in raster order of first pixel, U fully one label.
- Reset pulsed mid-GROW, then released -> run restarts; final SRAM is identical to an uninterrupted run, and `finish` was 0 during reset.
